// File: rtl/spi_rx_framer.sv
// -----------------------------------------------------------------------------
// spi_rx_framer
//   Assembles framed packets from a stream of 16-bit words delivered by an SPI
//   slave. A frame is: SYNC_WORD, length (1..MAX_LEN), payload words, and a
//   16-bit modulo-2^16 sum of the payload. A good frame is held in a one-frame
//   buffer until the consumer releases it. Bad length, bad checksum, an
//   inter-word timeout, or a new sync word arriving while a frame is held all
//   produce a one-cycle error pulse with a sticky reason code.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   word_valid   : one-cycle strobe, word_in holds a new SPI word
//   word_in      : received SPI word
//   pkt_valid    : a checksum-good frame is held
//   pkt_len      : payload word count of the held frame
//   pkt_rd_en    : read the word at the read pointer and advance it
//   pkt_rd_data  : registered payload word, valid the cycle after pkt_rd_en
//   pkt_done     : consumer releases the held frame
//   busy         : inside a frame (LEN, PAYLOAD or CHECK)
//   err_pulse    : one-cycle error strobe
//   err_code     : reason of the last error (1 length, 2 checksum, 3 timeout/overrun)
// -----------------------------------------------------------------------------
module spi_rx_framer #(
   parameter logic [15:0] SYNC_WORD   = 16'h09BB,
   parameter int          MAX_LEN     = 32,
   parameter int          TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        word_valid,
   input  logic [15:0] word_in,
   output logic        pkt_valid,
   output logic [5:0]  pkt_len,
   input  logic        pkt_rd_en,
   output logic [15:0] pkt_rd_data,
   input  logic        pkt_done,
   output logic        busy,
   output logic        err_pulse,
   output logic [1:0]  err_code
);

   localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [6:0]    MAX_LEN_W = 7'(MAX_LEN);

   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_SUM = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHECK   = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [5:0]      r_len;
   logic [5:0]      r_wr_ptr;
   logic [5:0]      r_rd_ptr;
   logic [15:0]     r_sum;
   logic [TW-1:0]   r_tmo;
   logic [15:0]     r_rd_data;
   logic            r_err_pulse;
   logic [1:0]      r_err_code;
   logic [15:0]     r_buf [MAX_LEN];

   logic            w_len_ok;
   logic            w_tmo_hit;
   logic            w_active;
   logic [5:0]      w_wr_ptr_inc;
   logic            w_err;
   logic [1:0]      w_err_code;

   assign w_len_ok     = (word_in[15:6] == 10'd0) && (word_in[5:0] != 6'd0) &&
                         ({1'b0, word_in[5:0]} <= MAX_LEN_W);
   assign w_active     = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
   // The counter reaches TIMEOUT_CYC on this edge only if no word arrives now.
   assign w_tmo_hit    = w_active && !word_valid && (r_tmo == TMO_LAST);
   assign w_wr_ptr_inc = r_wr_ptr + 6'd1;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_HUNT;
      else        r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_err_code  = 2'd0;
      case (r_state)
         S_HUNT: begin
            if (word_valid && (word_in == SYNC_WORD)) w_state_nxt = S_LEN;
         end
         S_LEN: begin
            if (word_valid) begin
               if (w_len_ok) begin
                  w_state_nxt = S_PAYLOAD;
               end else begin
                  w_state_nxt = S_HUNT;
                  w_err       = 1'b1;
                  w_err_code  = ERR_LEN;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_HUNT;
               w_err       = 1'b1;
               w_err_code  = ERR_TMO;
            end
         end
         S_PAYLOAD: begin
            if (word_valid) begin
               if (w_wr_ptr_inc == r_len) w_state_nxt = S_CHECK;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_HUNT;
               w_err       = 1'b1;
               w_err_code  = ERR_TMO;
            end
         end
         S_CHECK: begin
            if (word_valid) begin
               if (word_in == r_sum) begin
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_HUNT;
                  w_err       = 1'b1;
                  w_err_code  = ERR_SUM;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_HUNT;
               w_err       = 1'b1;
               w_err_code  = ERR_TMO;
            end
         end
         S_HOLD: begin
            if (pkt_done) w_state_nxt = S_HUNT;
            // A new frame start while one is held cannot be accepted: overrun.
            if (word_valid && (word_in == SYNC_WORD)) begin
               w_err      = 1'b1;
               w_err_code = ERR_TMO;
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy      = 1'b0;
      pkt_valid = 1'b0;
      case (r_state)
         S_LEN, S_PAYLOAD, S_CHECK: busy      = 1'b1;
         S_HOLD:                    pkt_valid = 1'b1;
         default: ;
      endcase
   end

   assign pkt_len     = r_len;
   assign pkt_rd_data = r_rd_data;
   assign err_pulse   = r_err_pulse;
   assign err_code    = r_err_code;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_sum       <= '0;
         r_tmo       <= '0;
         r_rd_data   <= '0;
         r_err_pulse <= 1'b0;
         r_err_code  <= '0;
      end else begin
         r_err_pulse <= w_err;
         if (w_err) r_err_code <= w_err_code;

         if ((r_state == S_LEN) && word_valid && w_len_ok) r_len <= word_in[5:0];

         // Every path back to HUNT (error, timeout, release) starts clean.
         if (w_state_nxt == S_HUNT) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_sum    <= '0;
            r_tmo    <= '0;
         end else begin
            if (w_active) r_tmo <= word_valid ? '0 : r_tmo + TW'(1);
            else          r_tmo <= '0;

            if ((r_state == S_PAYLOAD) && word_valid) begin
               r_wr_ptr <= w_wr_ptr_inc;
               r_sum    <= r_sum + word_in;
            end

            // Reaching here in HOLD implies pkt_done is low.
            if ((r_state == S_HOLD) && pkt_rd_en) begin
               r_rd_data <= r_buf[r_rd_ptr[AW-1:0]];
               if (r_rd_ptr != (r_len - 6'd1)) r_rd_ptr <= r_rd_ptr + 6'd1;
            end
         end
      end
   end

   // Payload storage, intentionally not reset.
   always_ff @(posedge clk) begin
      if ((r_state == S_PAYLOAD) && word_valid) r_buf[r_wr_ptr[AW-1:0]] <= word_in;
   end

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'h09BB, the frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 32, the maximum payload words per frame (range 1..63).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, the maximum clk cycles allowed between words inside a frame.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-006 SHALL have port word_valid  input  1  a one-cycle strobe marking that word_in holds a new received SPI word (driven by the SPI slave data_read).
REQ-007 SHALL have port word_in  input  16  the received SPI word (driven by the SPI slave byte_data_received).
REQ-008 SHALL have port pkt_valid  output  1  a complete, checksum-good frame is held in the buffer.
REQ-009 SHALL have port pkt_len  output  6  the payload word count of the held frame.
REQ-010 SHALL have port pkt_rd_en  input  1  advances the payload read pointer.
REQ-011 SHALL have port pkt_rd_data  output  16  the payload word at the read pointer, registered.
REQ-012 SHALL have port pkt_done  input  1  the consumer releases the held frame.
REQ-013 SHALL have port busy  output  1  the framer is inside a frame (any state other than HUNT or HOLD).
REQ-014 SHALL have port err_pulse  output  1  a one-cycle pulse on any frame error.
REQ-015 SHALL have port err_code  output  2  the reason for the last error: 1 = bad length, 2 = checksum, 3 = timeout or overrun.

Function
REQ-016 SHALL implement states HUNT, LEN, PAYLOAD, CHECK and HOLD.
REQ-017 HUNT: on word_valid with word_in==SYNC_WORD, SHALL go to LEN; all other words SHALL be discarded silently, including 16'h0000 idle words.
REQ-018 LEN: on word_valid, if word_in[15:6]==0 and 1<=word_in[5:0]<=MAX_LEN, SHALL latch the length and go to PAYLOAD.
REQ-019 LEN: any other length value SHALL raise err_pulse with err_code=1 and return to HUNT.
REQ-020 PAYLOAD: each word_valid SHALL write word_in to buffer[wr_ptr], increment wr_ptr and add word_in to a 16-bit running sum (wrap modulo 2^16).
REQ-021 PAYLOAD SHALL go to CHECK after the word_valid that makes wr_ptr equal the latched length.
REQ-022 CHECK: on word_valid, if word_in equals the running sum, SHALL go to HOLD with pkt_valid=1 in the next cycle.
REQ-023 CHECK: if word_in does not equal the running sum, SHALL raise err_pulse with err_code=2 and return to HUNT.
REQ-024 In LEN, PAYLOAD and CHECK, a counter SHALL clear on every word_valid; when it reaches TIMEOUT_CYC, the framer SHALL raise err_pulse with err_code=3 and go to HUNT.
REQ-025 HOLD SHALL drop incoming words; if a dropped word equals SYNC_WORD, it SHALL raise err_pulse with err_code=3 (overrun).
REQ-026 HOLD: pkt_rd_en SHALL make pkt_rd_data = buffer[rd_ptr] one cycle later and increment rd_ptr.
REQ-027 rd_ptr SHALL saturate at pkt_len-1, so repeated reads return the last word.
REQ-028 HOLD: pkt_done SHALL clear pkt_valid, rd_ptr and wr_ptr and go to HUNT in the next cycle; pkt_rd_en in that same cycle SHALL be ignored.
REQ-029 Outside HOLD, pkt_done and pkt_rd_en SHALL be ignored.
REQ-030 On every return to HUNT, the framer SHALL clear wr_ptr, the running sum and the timeout counter.
REQ-031 Buffer depth SHALL be MAX_LEN words of 16 bits, single frame only, no pipelining of a second frame.
REQ-032 err_pulse SHALL be exactly one cycle wide; err_code SHALL hold until the next error.

Reset
REQ-033 rst_n low SHALL asynchronously force state HUNT, pointers 0, sum 0, timeout counter 0, pkt_valid=0, pkt_len=0, pkt_rd_data=0, busy=0, err_pulse=0 and err_code=0.
REQ-034 Buffer contents SHALL be left uninitialised by reset.
REQ-035 Reset asserted mid-frame or during HOLD SHALL discard the frame without raising err_pulse.
REQ-036 After rst_n deasserts, the first word_valid SHALL be evaluated in HUNT.

Verification
REQ-037 Bench SHALL cover the good frame: words 09BB, 0003, 1111, 2222, 3333, 6666 -> pkt_valid=1, pkt_len=3; three pkt_rd_en reads -> 1111, 2222, 3333; pkt_done -> pkt_valid=0.
REQ-038 Bench SHALL cover a bad length: words 09BB, 0000 -> err_pulse with err_code=1, state HUNT; words 09BB, 0021 with MAX_LEN=32 -> err_code=1.
REQ-039 Bench SHALL cover checksum wrap: payload FFFF, 0002 and check word 0001 -> pkt_valid=1; check word 0002 instead -> err_code=2, no pkt_valid.
REQ-040 Bench SHALL cover timeout: 09BB, 0002, AAAA followed by TIMEOUT_CYC idle cycles -> err_code=3, busy=0; a following good frame SHALL be accepted.
REQ-041 Bench SHALL cover overrun: a frame held and a new 09BB frame sent before pkt_done -> err_code=3; the held data SHALL be unchanged when read.
REQ-042 Bench SHALL cover reset mid-payload: rst_n pulsed after two payload words -> all outputs at reset values and no err_pulse; a following good frame SHALL be accepted.
